// File: rtl/ofs_fim_pcie_ss_sb_seg_align_if.sv
// Bundle of the segmented side-band input stream and the aligned output stream.
// The slave modport is the aligner's view; the master modport is its environment.
interface ofs_fim_pcie_ss_sb_seg_align_if #(
    parameter int TDATA_W = 512,
    parameter int USER_W  = 10,
    parameter int HDR_W   = 256
);
    logic                      in_tvalid;
    logic                      in_tready;
    logic [TDATA_W-1:0]        in_tdata;
    logic [TDATA_W/8-1:0]      in_tkeep;
    logic [1:0]                in_seg_valid;
    logic [1:0]                in_seg_sop;
    logic [1:0]                in_seg_eop;
    logic [2*HDR_W-1:0]        in_seg_hdr;
    logic [USER_W-1:0]         in_tuser_vendor;

    logic                      out_tvalid;
    logic                      out_tready;
    logic [TDATA_W-1:0]        out_tdata;
    logic [TDATA_W/8-1:0]      out_tkeep;
    logic                      out_tlast;
    logic [USER_W+HDR_W-1:0]   out_tuser_vendor;

    modport master (
        output in_tvalid, in_tdata, in_tkeep, in_seg_valid, in_seg_sop, in_seg_eop,
               in_seg_hdr, in_tuser_vendor, out_tready,
        input  in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser_vendor
    );

    modport slave (
        input  in_tvalid, in_tdata, in_tkeep, in_seg_valid, in_seg_sop, in_seg_eop,
               in_seg_hdr, in_tuser_vendor, out_tready,
        output in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser_vendor
    );
endinterface

// File: rtl/ofs_fim_pcie_ss_sb_seg_align.sv
// Realigns a two-segment side-band stream so each output beat holds at most one TLP
// starting at tdata[0], with the segment header carried in the top of tuser_vendor.
module ofs_fim_pcie_ss_sb_seg_align #(
    parameter int TDATA_W = 512,
    parameter int USER_W  = 10,
    parameter int HDR_W   = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    ofs_fim_pcie_ss_sb_seg_align_if.slave     sb_bus
);
    localparam int SEG_W  = TDATA_W / 2;
    localparam int SEG_K  = SEG_W / 8;
    localparam int KEEP_W = TDATA_W / 8;
    localparam int OUT_U  = USER_W + HDR_W;

    typedef struct packed {
        logic              vld;
        logic              sop;
        logic              eop;
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] user;
        logic [SEG_K-1:0]  keep;
        logic [SEG_W-1:0]  data;
    } seg_t;

    seg_t               carry_reg, carry_next;
    logic               rdy_en_reg;
    logic               out_tvalid_reg, out_tvalid_next;
    logic [TDATA_W-1:0] out_tdata_reg, out_tdata_next;
    logic [KEEP_W-1:0]  out_tkeep_reg, out_tkeep_next;
    logic               out_tlast_reg, out_tlast_next;
    logic [OUT_U-1:0]   out_tuser_reg, out_tuser_next;

    logic               load;
    logic               in_ready;
    logic               accept;
    seg_t               in_seg [2];
    seg_t               q [3];
    seg_t               left_seg;
    logic               emit;
    logic               emit_two;

    // A carried eop segment must go out alone, so input waits for that cycle.
    assign load     = !out_tvalid_reg || sb_bus.out_tready;
    assign in_ready = rdy_en_reg && load && (!carry_reg.vld || !carry_reg.eop);
    assign accept   = sb_bus.in_tvalid && in_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_in_seg
        assign in_seg[gi] = '{
            vld  : accept & sb_bus.in_seg_valid[gi],
            sop  : sb_bus.in_seg_sop[gi],
            eop  : sb_bus.in_seg_eop[gi],
            hdr  : sb_bus.in_seg_hdr[gi*HDR_W +: HDR_W],
            user : sb_bus.in_tuser_vendor,
            keep : sb_bus.in_tkeep[gi*SEG_K +: SEG_K],
            data : sb_bus.in_tdata[gi*SEG_W +: SEG_W]
        };
    end

    always_comb begin
        q = '{default: '0};
        if (carry_reg.vld) begin
            q[0] = carry_reg;
            q[1] = in_seg[0];
            q[2] = in_seg[1];
        end else begin
            q[0] = in_seg[0];
            q[1] = in_seg[1];
        end
    end

    // A lone non-eop head segment is parked rather than sent as a half beat.
    always_comb begin
        emit     = 1'b0;
        emit_two = 1'b0;
        left_seg = '0;
        if (q[0].vld) begin
            if (q[0].eop) begin
                emit     = 1'b1;
                left_seg = q[1];
            end else if (q[1].vld) begin
                emit     = 1'b1;
                emit_two = 1'b1;
                left_seg = q[2];
            end else begin
                left_seg = q[0];
            end
        end
    end

    always_comb begin
        carry_next      = carry_reg;
        out_tvalid_next = out_tvalid_reg;
        out_tdata_next  = out_tdata_reg;
        out_tkeep_next  = out_tkeep_reg;
        out_tlast_next  = out_tlast_reg;
        out_tuser_next  = out_tuser_reg;
        if (load) begin
            carry_next      = left_seg;
            out_tvalid_next = emit;
            if (emit) begin
                out_tdata_next = {emit_two ? q[1].data : {SEG_W{1'b0}}, q[0].data};
                out_tkeep_next = {emit_two ? q[1].keep : {SEG_K{1'b0}}, q[0].keep};
                out_tlast_next = emit_two ? q[1].eop : 1'b1;
                out_tuser_next = {q[0].sop ? q[0].hdr : {HDR_W{1'b0}}, q[0].user};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_reg     <= 1'b0;
            carry_reg      <= '0;
            out_tvalid_reg <= 1'b0;
            out_tdata_reg  <= '0;
            out_tkeep_reg  <= '0;
            out_tlast_reg  <= 1'b0;
            out_tuser_reg  <= '0;
        end else begin
            rdy_en_reg     <= 1'b1;
            carry_reg      <= carry_next;
            out_tvalid_reg <= out_tvalid_next;
            out_tdata_reg  <= out_tdata_next;
            out_tkeep_reg  <= out_tkeep_next;
            out_tlast_reg  <= out_tlast_next;
            out_tuser_reg  <= out_tuser_next;
        end
    end

    assign sb_bus.in_tready        = in_ready;
    assign sb_bus.out_tvalid       = out_tvalid_reg;
    assign sb_bus.out_tdata        = out_tdata_reg;
    assign sb_bus.out_tkeep        = out_tkeep_reg;
    assign sb_bus.out_tlast        = out_tlast_reg;
    assign sb_bus.out_tuser_vendor = out_tuser_reg;

`ifndef SYNTHESIS
    // Input-side packet framing tracker, used only to flag illegal upstream traffic.
    logic pkt_open_reg;
    logic open_mid;
    logic open_end;

    assign open_mid = sb_bus.in_seg_valid[0] ? !sb_bus.in_seg_eop[0] : pkt_open_reg;
    assign open_end = sb_bus.in_seg_valid[1] ? !sb_bus.in_seg_eop[1] : open_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_open_reg <= 1'b0;
        end else if (accept) begin
            pkt_open_reg <= open_end;
        end
    end

    a_seg1_without_seg0: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && sb_bus.in_seg_valid[1] && !sb_bus.in_seg_valid[0]));
    a_seg0_framing: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && sb_bus.in_seg_valid[0] && (sb_bus.in_seg_sop[0] == pkt_open_reg)));
    a_seg1_framing: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && sb_bus.in_seg_valid[1] && (sb_bus.in_seg_sop[1] == open_mid)));
    a_keep_on_idle_seg: assert property (@(posedge clk) disable iff (!rst_n)
        !(sb_bus.in_tvalid &&
          ((!sb_bus.in_seg_valid[0] && |sb_bus.in_tkeep[SEG_K-1:0]) ||
           (!sb_bus.in_seg_valid[1] && |sb_bus.in_tkeep[KEEP_W-1:SEG_K]))));
`endif
endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb_seg_align.sv
// Randomized scoreboard bench for the side-band segment aligner: TLPs are generated
// as segment lists and the expected output is formed by pairing segments per TLP.
`timescale 1ns/1ps
module tb_ofs_fim_pcie_ss_sb_seg_align;
    localparam int TDATA_W = 512;
    localparam int USER_W  = 10;
    localparam int HDR_W   = 256;
    localparam int SEG_W   = TDATA_W / 2;
    localparam int SEG_K   = SEG_W / 8;
    localparam int KEEP_W  = TDATA_W / 8;
    localparam int OUT_U   = USER_W + HDR_W;
    localparam int CW      = TDATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofs_fim_pcie_ss_sb_seg_align_if #(.TDATA_W(TDATA_W), .USER_W(USER_W), .HDR_W(HDR_W)) sb_if ();

    ofs_fim_pcie_ss_sb_seg_align #(.TDATA_W(TDATA_W), .USER_W(USER_W), .HDR_W(HDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sb_bus (sb_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]         v;
        logic [1:0]         sop;
        logic [1:0]         eop;
        logic [TDATA_W-1:0] data;
        logic [KEEP_W-1:0]  keep;
        logic [2*HDR_W-1:0] hdr;
        logic [USER_W-1:0]  user;
        int                 gap;
    } in_beat_t;

    typedef struct {
        logic [TDATA_W-1:0] data;
        logic [KEEP_W-1:0]  keep;
        logic               last;
        logic [OUT_U-1:0]   tuser;
    } out_beat_t;

    in_beat_t  in_q [$];
    out_beat_t exp_q [$];
    in_beat_t  pb;
    int        pb_fill = 0;
    int        gap_pct = 0;
    int        rdy_mode = 0;

    function automatic logic [CW-1:0] rand_bits();
        logic [CW-1:0] r;
        for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SEG_K-1:0] rand_keep();
        int n = $urandom_range(1, SEG_K);
        logic [SEG_K-1:0] kk = '0;
        for (int i = 0; i < n; i++) kk[i] = 1'b1;
        return kk;
    endfunction

    task automatic clear_pb();
        pb.v = '0; pb.sop = '0; pb.eop = '0; pb.data = '0;
        pb.keep = '0; pb.hdr = '0; pb.user = '0; pb.gap = 0;
    endtask

    task automatic flush_beat();
        if (pb_fill > 0) begin
            in_q.push_back(pb);
            pb_fill = 0;
        end
    endtask

    task automatic push_seg(input logic [SEG_W-1:0] d, input logic [SEG_K-1:0] k,
                            input logic sop, input logic eop, input logic [HDR_W-1:0] h,
                            output logic [USER_W-1:0] u);
        if (pb_fill == 0) begin
            clear_pb();
            pb.user = USER_W'($urandom);
            pb.gap  = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
        end
        pb.v[pb_fill]   = 1'b1;
        pb.sop[pb_fill] = sop;
        pb.eop[pb_fill] = eop;
        pb.data[pb_fill*SEG_W +: SEG_W] = d;
        pb.keep[pb_fill*SEG_K +: SEG_K] = k;
        pb.hdr[pb_fill*HDR_W +: HDR_W]  = h;
        u = pb.user;
        pb_fill++;
        if (pb_fill == 2) flush_beat();
    endtask

    // Reference: output beat i of a TLP holds segments 2i and 2i+1, header on beat 0 only,
    // user of the input beat that delivered segment 2i.
    task automatic add_tlp(input int nseg, input bit partial, input logic [HDR_W-1:0] h,
                           input bit rand_flush);
        logic [SEG_W-1:0]  d [$];
        logic [SEG_K-1:0]  k [$];
        logic [USER_W-1:0] u [$];
        logic [SEG_W-1:0]  dd;
        logic [SEG_K-1:0]  kk;
        logic [USER_W-1:0] uu;
        logic [HDR_W-1:0]  hh;
        out_beat_t         ob;
        for (int i = 0; i < nseg; i++) begin
            bit last = (i == nseg - 1) && !partial;
            dd = SEG_W'(rand_bits());
            kk = last ? rand_keep() : '1;
            hh = (i == 0) ? h : HDR_W'(rand_bits());
            push_seg(dd, kk, i == 0, last, hh, uu);
            d.push_back(dd); k.push_back(kk); u.push_back(uu);
        end
        if (!partial) begin
            for (int i = 0; i < nseg; i += 2) begin
                ob.data = '0;
                ob.keep = '0;
                ob.data[SEG_W-1:0] = d[i];
                ob.keep[SEG_K-1:0] = k[i];
                if (i + 1 < nseg) begin
                    ob.data[TDATA_W-1:SEG_W] = d[i+1];
                    ob.keep[KEEP_W-1:SEG_K]  = k[i+1];
                end
                ob.last  = (i + 2 >= nseg);
                ob.tuser = {(i == 0) ? h : {HDR_W{1'b0}}, u[i]};
                exp_q.push_back(ob);
            end
            if (rand_flush && pb_fill == 1 && $urandom_range(0, 1) == 1) flush_beat();
        end
    endtask

    task automatic idle_inputs();
        sb_if.in_tvalid = 1'b0;
        sb_if.in_tdata = '0; sb_if.in_tkeep = '0;
        sb_if.in_seg_valid = '0; sb_if.in_seg_sop = '0; sb_if.in_seg_eop = '0;
        sb_if.in_seg_hdr = '0; sb_if.in_tuser_vendor = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic drive_beat(input in_beat_t b);
        int budget = 0;
        repeat (b.gap) begin @(posedge clk); #1; end
        sb_if.in_tvalid = 1'b1;
        sb_if.in_tdata = b.data; sb_if.in_tkeep = b.keep;
        sb_if.in_seg_valid = b.v; sb_if.in_seg_sop = b.sop; sb_if.in_seg_eop = b.eop;
        sb_if.in_seg_hdr = b.hdr; sb_if.in_tuser_vendor = b.user;
        forever begin
            @(negedge clk);
            if (sb_if.in_tready) break;
            budget++;
            if (budget > 2000) begin
                check("accept_timeout", CW'(1), CW'(0));
                break;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic drive_all();
        while (in_q.size() > 0) drive_beat(in_q.pop_front());
    endtask

    task automatic wait_drain(input string tag);
        int budget = 0;
        while (exp_q.size() > 0 && budget < 60000) begin
            @(negedge clk);
            budget++;
        end
        check(tag, CW'(exp_q.size()), CW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        sb_if.out_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       sb_if.out_tready = 1'b1;
                1:       sb_if.out_tready = ($urandom_range(0, 99) < 30);
                default: sb_if.out_tready = 1'b0;
            endcase
        end
    end

    initial begin
        out_beat_t ob;
        int n_out = 0;
        forever begin
            @(negedge clk);
            if (rst_n && sb_if.out_tvalid && sb_if.out_tready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_beat[%0d]", n_out), CW'(1), CW'(0));
                end else begin
                    ob = exp_q.pop_front();
                    check($sformatf("tdata[%0d]", n_out), sb_if.out_tdata, ob.data);
                    check($sformatf("tkeep[%0d]", n_out), CW'(sb_if.out_tkeep), CW'(ob.keep));
                    check($sformatf("tlast[%0d]", n_out), CW'(sb_if.out_tlast), CW'(ob.last));
                    check($sformatf("tuser[%0d]", n_out), CW'(sb_if.out_tuser_vendor), CW'(ob.tuser));
                end
                n_out++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_beat_t b;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_tvalid", CW'(sb_if.out_tvalid), CW'(0));
        check("rst_in_tready", CW'(sb_if.in_tready), CW'(0));
        check("rst_out_tdata", sb_if.out_tdata, CW'(0));
        check("rst_out_tkeep", CW'(sb_if.out_tkeep), CW'(0));
        check("rst_out_tlast", CW'(sb_if.out_tlast), CW'(0));
        check("rst_out_tuser", CW'(sb_if.out_tuser_vendor), CW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned 3-beat TLP, one-cycle latency on the first beat
        add_tlp(6, 1'b0, HDR_W'(rand_bits()), 1'b0);
        drive_beat(in_q.pop_front());
        @(negedge clk);
        check("first_latency", CW'(sb_if.out_tvalid), CW'(1));
        @(posedge clk); #1;
        drive_all();
        wait_drain("drain_aligned");

        // Two single-segment TLPs in one beat
        add_tlp(1, 1'b0, HDR_W'(32'hA), 1'b0);
        add_tlp(1, 1'b0, HDR_W'(32'hB), 1'b0);
        drive_beat(in_q.pop_front());
        @(negedge clk);
        check("dual_stall", CW'(sb_if.in_tready), CW'(0));
        @(negedge clk);
        check("dual_resume", CW'(sb_if.in_tready), CW'(1));
        @(posedge clk); #1;
        wait_drain("drain_dual");

        // TLP starting in segment 1
        add_tlp(1, 1'b0, HDR_W'(rand_bits()), 1'b0);
        add_tlp(3, 1'b0, HDR_W'(rand_bits()), 1'b0);
        drive_all();
        wait_drain("drain_shift");

        // Same, with five idle cycles while the head segment is parked
        add_tlp(1, 1'b0, HDR_W'(rand_bits()), 1'b0);
        add_tlp(3, 1'b0, HDR_W'(rand_bits()), 1'b0);
        drive_beat(in_q.pop_front());
        @(negedge clk);
        check("gap_first_out", CW'(sb_if.out_tvalid), CW'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("gap_no_output[%0d]", i), CW'(sb_if.out_tvalid), CW'(0));
        end
        @(posedge clk); #1;
        drive_all();
        wait_drain("drain_gap");

        // Random TLPs with 30% output ready and input gaps
        rdy_mode = 1;
        gap_pct  = 15;
        for (int t = 0; t < 1000; t++)
            add_tlp($urandom_range(1, 16), 1'b0, HDR_W'(rand_bits()), 1'b1);
        flush_beat();
        drive_all();
        wait_drain("drain_random");

        // Reset while an output is stalled and a head segment is carried
        rdy_mode = 2;
        gap_pct  = 0;
        @(posedge clk); #1;
        add_tlp(1, 1'b0, HDR_W'(rand_bits()), 1'b0);
        add_tlp(1, 1'b1, HDR_W'(rand_bits()), 1'b0);
        drive_beat(in_q.pop_front());
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_valid", CW'(sb_if.out_tvalid), CW'(1));
        check("pre_reset_ready", CW'(sb_if.in_tready), CW'(0));
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", CW'(sb_if.out_tvalid), CW'(0));
        check("reset_async_ready", CW'(sb_if.in_tready), CW'(0));
        check("reset_async_tdata", sb_if.out_tdata, CW'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        add_tlp(4, 1'b0, HDR_W'(rand_bits()), 1'b0);
        add_tlp(3, 1'b0, HDR_W'(rand_bits()), 1'b0);
        flush_beat();
        drive_all();
        wait_drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ofs_fim_pcie_ss_sb_seg_align.md
Name: ofs_fim_pcie_ss_sb_seg_align

Overview:
- Upstream feeder of the side-band to in-band header converter. Input is a PCIe SS side-band AXI-S whose beats carry two equal segments, and each segment may start or end a TLP.
- Output carries at most one TLP per beat, with every SOP at tdata[0]. Its header sits in the high bits of tuser_vendor, exactly as the header converter requires.
- Realigns packets that start in segment 1 by carrying one segment across beats.

Parameters:
- TDATA_W, 512, beat width; must be even and divisible by 16. SEG_W = TDATA_W/2 and SEG_K = SEG_W/8 are derived.
- USER_W, 10, per-beat tuser_vendor bits passed through.
- HDR_W, 256, side-band header width, one header per segment.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_tvalid  in  1  input beat valid
- in_tready  out  1  input beat accepted
- in_tdata  in  TDATA_W  segment 0 = [SEG_W-1:0], segment 1 = upper half
- in_tkeep  in  TDATA_W/8  byte enables
- in_seg_valid  in  2  segment carries data
- in_seg_sop  in  2  segment starts a TLP
- in_seg_eop  in  2  segment ends a TLP
- in_seg_hdr  in  2*HDR_W  header for segment s at [s*HDR_W +: HDR_W]; valid only with sop
- in_tuser_vendor  in  USER_W  beat sideband; travels with each segment
- out_tvalid  out  1  output valid
- out_tready  in  1  output ready
- out_tdata  out  TDATA_W  aligned data
- out_tkeep  out  TDATA_W/8  aligned byte enables
- out_tlast  out  1  end of TLP
- out_tuser_vendor  out  USER_W+HDR_W  {header, user}; header is zero on non-SOP beats

Behaviour:
- Segment queue Q per cycle = [carry if held] ++ [in seg0, in seg1 if in_tvalid and valid]. The beat builder takes:
  - Q[0] into output segment 0.
  - If Q[0] has eop: the beat ends, out_tlast=1, and the upper tkeep/tdata are 0.
  - Otherwise Q[1] goes into output segment 1, with out_tlast = Q[1].eop.
  - The leftover segment, at most one, loads the carry register: data, keep, sop, eop, hdr, user.
- Non-final output beats are always fully populated. A carry holding a non-eop segment waits for the next input beat and never emits a half beat.
- in_tready = output stage can load AND (carry empty OR carry not eop).
- Carry holding an eop segment is a single-segment TLP. It is emitted alone and input is stalled for that cycle.
- Carry empty, input seg0 eop and seg1 valid: emit seg0 alone, carry seg1.
- out_tuser_vendor = {Q[0].sop ? Q[0].hdr : 0, Q[0].user}.
- Output stage is registered. It loads when !out_tvalid || out_tready. Latency from input acceptance to out_tvalid is 1 cycle when the carry is empty.
- out_tvalid/out_tdata/out_tkeep/out_tlast are held stable while out_tvalid && !out_tready.
- Reset (async, rst_n=0): out_tvalid=0, in_tready=0, carry empty, out_tdata/out_tkeep/out_tlast/out_tuser_vendor=0.
- Reset mid-packet discards the partial TLP and the carry. After release, the first accepted segment must be an SOP.
- Illegal input, flagged by simulation-only assertions; hardware behaviour is unspecified:
  - seg1 valid with seg0 invalid.
  - sop while a TLP is open.
  - non-sop segment while no TLP is open.
  - seg_valid=0 while in_tkeep for that segment is nonzero.
- in_tvalid=0 with a non-eop carry: no output and no state change.
- out_tready stuck at 0: carry and output register hold and in_tready=0, so there is no loss and no duplication.

Test Plan:
- Aligned pass-through: 3-beat TLP in seg0/seg1 (sop seg0, eop seg1 of beat 3), out_tready=1 -> 3 output beats, identical data, hdr only on beat 1, tlast on beat 3, first data 1 cycle after accept.
- Two TLPs in one beat: seg0 sop+eop hdr=0xA, seg1 sop+eop hdr=0xB -> two beats, each tlast=1, upper tkeep=0, hdrs 0xA then 0xB, in_tready=0 for exactly one cycle.
- Shifted TLP: seg1 sop of a 3-segment TLP (D0 in beat N seg1, D1/D2 in beat N+1) -> out beat {D1,D0} tlast=0 hdr set, then {0,D2} tlast=1 with tkeep[SEG_K +: SEG_K]=0.
- Shifted TLP with gap: after D0 is carried, in_tvalid=0 for 5 cycles -> out_tvalid stays 0 until D1 arrives; no partial beat.
- Backpressure: random out_tready at 30% duty over 1000 random legal TLPs (1–16 segments, random start segment) -> scoreboard matches byte-exact order, hdr/user per TLP, every SOP at bit 0.
- Reset mid-TLP with a carry held: assert rst_n=0 -> out_tvalid=0 immediately; after release a fresh TLP comes out correctly with no stale carry data.
